input_conditioner: RTL and testbench
====================================

# input_conditioner

Front-end conditioning stage between the board pins and the game datapath/controller. Synchronises, debounces and edge-detects the four push-buttons (`key[3:0]`, active-low on the board) and the `enter` slide switch (`sw[0]`, active-high). Delivers clean active-high level and single-cycle press pulses, so one physical press equals exactly one event downstream. Sits in `Topo` in front of `Datapath.key` and `Controle.enter`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive cycles an input must hold a new value before it is accepted (20 ms at 50 MHz); legal ≥ 2.
- `REPEAT_DELAY`, 25_000_000, cycles a key must stay held before the first repeat pulse (used only with `AUTOREPEAT_EN`).
- `REPEAT_PERIOD`, 10_000_000, cycles between subsequent repeat pulses (used only with `AUTOREPEAT_EN`).

Ports (one clock; reset is synchronous and active-high):
- `clock_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `key`  in  4  raw push-buttons, active-low, asynchronous.
- `enter_raw`  in  1  raw enter switch, active-high, asynchronous.
- `key_level`  out  4  debounced key state, 1 = pressed.
- `key_pulse`  out  4  one-cycle pulse per accepted press (and per repeat).
- `enter_level`  out  1  debounced enter state.
- `enter_pulse`  out  1  one-cycle pulse on accepted 0→1 of enter.

## Operation
- Five independent channels. Each channel: inversion (keys only) → 2-FF synchroniser → debounce counter → stable register → rising-edge pulse.
- Synchroniser FFs reset to the idle value (0 after inversion).
- Debounce:
  - If `sync != stable`: if `cnt == DEBOUNCE_CYCLES-1`, then `stable <= sync` and `cnt <= 0`; otherwise `cnt <= cnt+1`.
  - If `sync == stable`: `cnt <= 0`. Any bounce shorter than `DEBOUNCE_CYCLES` is discarded.
- Counter width: `$clog2(DEBOUNCE_CYCLES)`. No wrap is possible, because the counter is cleared at terminal count.
- Pulse: asserted for exactly one cycle when `stable` goes 0→1 while the channel is armed. No pulse on release.
- Arming window:
  - For `DEBOUNCE_CYCLES` cycles after reset deassertion, all channels are unarmed. During this window `stable <= sync` every cycle and no pulses are produced.
  - After the window, all channels arm together.
  - A switch or key already active at reset therefore yields `*_level = 1` but no pulse.
- Output reset values: all `*_level`, all `*_pulse`, counters and arm counter = 0.
- Reset asserted mid-debounce or mid-pulse: everything clears on the next edge. A pending pulse is lost.
- Channels are fully independent. Simultaneous presses on several keys produce pulses in the same cycle.

## Timing
- Let edge k be the first edge at which the synchroniser's first FF captures the new raw value. The synchronised value is visible after edge k+1. The stable register and `*_pulse` update at edge k+1+`DEBOUNCE_CYCLES`.
- The pulse is high for the single cycle after that edge.
- Press-to-pulse latency is `DEBOUNCE_CYCLES`+2 edges.
- Level changes on the same edge as the pulse.
- Release latency equals press latency.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `INPUT_COND_AUTOREPEAT_EN` defined:
  - Key channels only (never enter) get a hold counter that starts at the accepted press.
  - An extra `key_pulse` fires after `REPEAT_DELAY` held cycles, then every `REPEAT_PERIOD` cycles while the key stays pressed.
  - Release or reset clears the hold counter.
- Macro undefined: exactly one pulse per accepted press. Repeat logic and parameters are unused and not synthesised.

## Structure
- Shared package/header `input_cond_pkg.vh`:
  - `NUM_KEYS = 4`
  - default debounce/repeat constants
  - simulation-override values (`DEBOUNCE_CYCLES = 4`, `REPEAT_DELAY = 8`, `REPEAT_PERIOD = 3`)
- Sub-module `debounce_channel` (parameters `DEBOUNCE_CYCLES`, `INVERT`, `REPEAT`): sync + counter + stable + pulse + optional repeat.
- Top level: instantiates the channel four times with `INVERT=1`, once with `INVERT=0`, plus the shared arm counter.

## Test plan
Bench uses `DEBOUNCE_CYCLES = 4`.
1. Reset held 3 cycles with `key = 4'hF`, `enter_raw = 0`; release and wait 4 cycles → all outputs 0, arm asserted, no pulses.
2. Clean press: `key[2]` driven 0 and held → `key_pulse = 4'b0100` for exactly 1 cycle, 6 edges after the change. `key_level[2]` = 1 from the same edge. Release yields no pulse; `key_level[2]` drops 6 edges after release.
3. Bounce: `key[0]` toggles 0/1 with 3-cycle low segments 5 times, then holds low → exactly one pulse, 6 edges after the final low begins.
4. `enter_raw = 1` during reset and after it → `enter_level = 1` once arming completes; `enter_pulse` never asserts. Toggle 0 then 1 → one pulse.
5. `key[1]` and `key[3]` pressed on the same cycle → `key_pulse = 4'b1010` in one cycle. Reset asserted 2 cycles into a new press → no pulse; outputs 0.
6. With `INPUT_COND_AUTOREPEAT_EN` (`REPEAT_DELAY = 8`, `REPEAT_PERIOD = 3`): hold `key[0]` 20 cycles after acceptance → pulses at acceptance, +8, +11, +14, +17. Without the macro → single pulse.

Source files
------------

// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared constants for the input conditioner
package input_cond_pkg;
  localparam int NUM_KEYS = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

  // Short values so simulations finish quickly
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_REPEAT_DELAY    = 8;
  localparam int SIM_REPEAT_PERIOD   = 3;
endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: sync, debounce, stable level, press pulse
// Optional key auto-repeat when INPUT_COND_AUTOREPEAT_EN is defined.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit INVERT          = 1'b0,
  parameter bit REPEAT          = 1'b0
`ifdef INPUT_COND_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 3
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic armed,
  output logic level,
  output logic pulse
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, stable;
  logic [CW-1:0] cnt;
  logic          accept, press, rep_fire;

  assign accept = armed && (sync2 != stable) && (cnt == CNT_LAST);
  assign press  = accept && sync2;
  assign level  = stable;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= raw ^ INVERT;
      sync2 <= sync1;
      pulse <= press | rep_fire;
      // Until armed, follow the input silently so a held input never pulses
      if (!armed) begin
        stable <= sync2;
        cnt    <= '0;
      end else if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef INPUT_COND_AUTOREPEAT_EN
  if (REPEAT) begin : g_repeat
    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic          held;
    logic [HW-1:0] hold_cnt;

    // An accepted release on the same edge wins over a due repeat
    assign rep_fire = held && (hold_cnt == HOLD_LAST) && !accept;

    always_ff @(posedge clk) begin
      if (reset) begin
        held     <= 1'b0;
        hold_cnt <= '0;
      end else if (press) begin
        held     <= 1'b1;
        hold_cnt <= '0;
      end else if (accept || !stable) begin
        held     <= 1'b0;
        hold_cnt <= '0;
      end else if (held) begin
        hold_cnt <= (hold_cnt == HOLD_LAST) ? HOLD_RELOAD : hold_cnt + 1'b1;
      end
    end
  end else begin : g_no_repeat
    assign rep_fire = 1'b0;
  end
`else
  assign rep_fire = REPEAT & 1'b0;
`endif
endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced levels and press pulses for key[3:0] and enter
// Auto-repeat on keys is enabled by defining INPUT_COND_AUTOREPEAT_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clock_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                enter_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic                enter_level,
  output logic                enter_pulse
);
  localparam int AW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
    $error("input_conditioner: illegal debounce/repeat parameters");
  end

  logic [AW-1:0] arm_cnt;
  logic          armed;

  assign armed = (arm_cnt == AW'(DEBOUNCE_CYCLES));

  always_ff @(posedge clock_50) begin
    if (reset) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (1'b1),
      .REPEAT         (1'b1)
`ifdef INPUT_COND_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk  (clock_50),
      .reset(reset),
      .raw  (key[i]),
      .armed(armed),
      .level(key_level[i]),
      .pulse(key_pulse[i])
    );
  end

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INVERT         (1'b0),
    .REPEAT         (1'b0)
`ifdef INPUT_COND_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
  ) u_enter (
    .clk  (clock_50),
    .reset(reset),
    .raw  (enter_raw),
    .armed(armed),
    .level(enter_level),
    .pulse(enter_pulse)
  );
endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - self-checking bench for input_conditioner
// Expected pulses go to a scoreboard queue; INPUT_COND_AUTOREPEAT_EN selects repeat expectations.
module tb_input_conditioner;
  import input_cond_pkg::*;

  localparam int LAT = SIM_DEBOUNCE_CYCLES + 2;

  logic       clock_50 = 1'b0;
  logic       reset;
  logic [3:0] key;
  logic       enter_raw;
  logic [3:0] key_level, key_pulse;
  logic       enter_level, enter_pulse;

  input_conditioner #(
    .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (SIM_REPEAT_DELAY),
    .REPEAT_PERIOD  (SIM_REPEAT_PERIOD)
  ) dut (
    .clock_50   (clock_50),
    .reset      (reset),
    .key        (key),
    .enter_raw  (enter_raw),
    .key_level  (key_level),
    .key_pulse  (key_pulse),
    .enter_level(enter_level),
    .enter_pulse(enter_pulse)
  );

  always #10 clock_50 = ~clock_50;

  int cyc = 0;
  always @(posedge clock_50) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] kp;
    logic       ep;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] key;
    logic       enter;
    int         wait_n;
    logic [3:0] push_kp;
    logic       push_ep;
    logic [3:0] exp_kl;
    logic       exp_el;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock_50);
  endtask

  task automatic expect_pulse(input int at, input logic [3:0] kp, input logic ep);
    exp_t e;
    e.cyc = at;
    e.kp  = kp;
    e.ep  = ep;
    sb.push_back(e);
  endtask

  function automatic vec_t mkv(input string name, input logic [3:0] k, input logic en, input int w,
                               input logic [3:0] pkp, input logic pep,
                               input logic [3:0] kl, input logic el);
    vec_t v;
    v.name = name; v.key = k; v.enter = en; v.wait_n = w;
    v.push_kp = pkp; v.push_ep = pep; v.exp_kl = kl; v.exp_el = el;
    return v;
  endfunction

  // Scoreboard monitor: every pulse must match the queue head in cycle and value
  always @(negedge clock_50) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse: no pulse observed, expected key_pulse=%b enter_pulse=%b at cycle %0d",
               sb[0].kp, sb[0].ep, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (key_pulse != 4'b0 || enter_pulse) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got key_pulse=%b enter_pulse=%b at cycle %0d, expected none",
                 key_pulse, enter_pulse, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.kp != key_pulse || e.ep != enter_pulse ||
            (key_level & e.kp) != e.kp || (e.ep && !enter_level)) begin
          errors++;
          $display("FAIL pulse_match: got key_pulse=%b enter_pulse=%b level=%b/%b at cycle %0d, expected key_pulse=%b enter_pulse=%b at cycle %0d",
                   key_pulse, enter_pulse, key_level, enter_level, cyc, e.kp, e.ep, e.cyc);
        end
      end
    end
  end

  initial begin
    int acc;
    reset = 1'b1; key = 4'hF; enter_raw = 1'b0;

    vecs.push_back(mkv("press_k2",     4'hB, 1'b0, 8, 4'b0100, 1'b0, 4'b0100, 1'b0));
    vecs.push_back(mkv("rel_k2_early", 4'hF, 1'b0, 5, 4'b0000, 1'b0, 4'b0100, 1'b0));
    vecs.push_back(mkv("rel_k2",       4'hF, 1'b0, 1, 4'b0000, 1'b0, 4'b0000, 1'b0));
    vecs.push_back(mkv("press_k1_k3",  4'h5, 1'b0, 8, 4'b1010, 1'b0, 4'b1010, 1'b0));
    vecs.push_back(mkv("rel_k1_k3",    4'hF, 1'b0, 8, 4'b0000, 1'b0, 4'b0000, 1'b0));
    vecs.push_back(mkv("enter_on",     4'hF, 1'b1, 8, 4'b0000, 1'b1, 4'b0000, 1'b1));
    vecs.push_back(mkv("enter_off",    4'hF, 1'b0, 8, 4'b0000, 1'b0, 4'b0000, 1'b0));
    vecs.push_back(mkv("k0_early",     4'hE, 1'b0, 5, 4'b0001, 1'b0, 4'b0000, 1'b0));
    vecs.push_back(mkv("k0_accept",    4'hE, 1'b0, 1, 4'b0000, 1'b0, 4'b0001, 1'b0));
    vecs.push_back(mkv("k0_rel",       4'hF, 1'b0, 8, 4'b0000, 1'b0, 4'b0000, 1'b0));

    // Reset and arming window
    step(3);
    reset = 1'b0;
    step(3);
    chk("arm_not_yet", 32'(dut.armed), 32'd0);
    step(1);
    chk("reset_outputs", {key_level, key_pulse, enter_level, enter_pulse}, 10'd0);
    chk("armed", 32'(dut.armed), 32'd1);

    // Table-driven presses and releases
    foreach (vecs[i]) begin
      key = vecs[i].key;
      enter_raw = vecs[i].enter;
      if (vecs[i].push_kp != 4'b0 || vecs[i].push_ep)
        expect_pulse(cyc + LAT, vecs[i].push_kp, vecs[i].push_ep);
      step(vecs[i].wait_n);
      chk({vecs[i].name, "_level"}, {key_level, enter_level}, {vecs[i].exp_kl, vecs[i].exp_el});
    end

    // Bounce: five 3-cycle lows are all rejected, final held low gives one pulse
    for (int b = 0; b < 5; b++) begin
      key = 4'hE; step(3);
      key = 4'hF; step(2);
    end
    chk("bounce_level", {28'd0, key_level}, 32'd0);
    key = 4'hE;
    expect_pulse(cyc + LAT, 4'b0001, 1'b0);
    step(10);
    chk("bounce_held_level", {28'd0, key_level}, 32'h1);
    key = 4'hF;
    step(8);

    // Enter held through reset: level follows, no pulse; toggle gives one pulse
    enter_raw = 1'b1;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(4);
    chk("enter_at_reset", {key_level, enter_level}, 5'b0000_1);
    enter_raw = 1'b0; step(8);
    chk("enter_toggle_off", 32'(enter_level), 32'd0);
    enter_raw = 1'b1;
    expect_pulse(cyc + LAT, 4'b0000, 1'b1);
    step(8);
    chk("enter_toggle_on", 32'(enter_level), 32'd1);
    enter_raw = 1'b0; step(8);

    // Reset two cycles into a press loses the pending pulse
    key = 4'h7;
    step(2);
    reset = 1'b1;
    step(1);
    chk("reset_mid_press", {key_level, key_pulse, enter_level, enter_pulse}, 10'd0);
    step(2);
    reset = 1'b0;
    step(4);
    chk("held_after_reset", {28'd0, key_level}, 32'h8);
    key = 4'hF; step(8);
    chk("held_after_reset_rel", {28'd0, key_level}, 32'h0);

    // Long hold of key[0]; release accepted exactly 20 cycles after the press
    key = 4'hE;
    acc = cyc + LAT;
    expect_pulse(acc, 4'b0001, 1'b0);
`ifdef INPUT_COND_AUTOREPEAT_EN
    expect_pulse(acc + 8,  4'b0001, 1'b0);
    expect_pulse(acc + 11, 4'b0001, 1'b0);
    expect_pulse(acc + 14, 4'b0001, 1'b0);
    expect_pulse(acc + 17, 4'b0001, 1'b0);
`endif
    step(LAT + 14);
    chk("long_hold_level", {28'd0, key_level}, 32'h1);
    key = 4'hF;
    step(8);
    chk("long_hold_rel", {28'd0, key_level}, 32'h0);

    step(4);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
